reaction_game_ctrl: RTL and testbench
=====================================

Name: reaction_game_ctrl

Overview:
- Top-level sequencer for the FPGA reaction game, clocked at 500 Hz (2 ms per tick).
- Runs the sequence: mode menu, random arm delay, GO, then a result or fault screen.
- Drives the number/select/mode inputs of the 4-digit seven-segment display driver and the GO LED.
- Takes debounced button levels; the display driver handles all multiplexing and blinking.

Parameters:
- DELAY_MIN_TICKS, 250, minimum arm delay in ticks (500 ms)
- LIMIT_EASY_MS, 2000, reaction timeout in mode 00
- LIMIT_REG_MS, 1000, reaction timeout in mode 01
- LIMIT_HARD_MS, 500, reaction timeout in mode 10
- MS_PER_TICK, 2, ms added to elapsed time per tick
- LFSR_SEED, 8'h01, LFSR reset value (must be nonzero)

Ports:
- clk_500Hz  in  1  system tick clock
- rst  in  1  asynchronous, active-high reset
- btn_start  in  1  debounced level, synchronous to clk_500Hz
- btn_react  in  1  debounced level, synchronous
- btn_mode  in  1  debounced level, synchronous
- number  out  14  value to display, 0..9999
- select  out  2  0 = mode menu, 1 = steady number, 2 = blinking number
- mode  out  2  00 easy, 01 regular, 10 hard; 11 never driven
- led_go  out  1  high while waiting for the reaction press

Behaviour:
- Reset (async, rst=1): state MENU; number=0, select=0, mode=00, led_go=0; button-history regs=0; LFSR=LFSR_SEED; counters=0.
- Edge detect: press = btn & ~btn_prev, evaluated combinationally. btn_prev is registered every tick. Held buttons produce exactly one press.
- All outputs are registered. A state change and its outputs appear at the clock edge that samples the press (one-tick latency).
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances every tick in every state. Never zero.
- MENU (select=0):
  - mode press: mode cycles 00→01→10→00.
  - start press: latch delay_cnt = DELAY_MIN_TICKS + lfsr (zero-extended to 10 bits); number=0; go to ARM.
  - react press: ignored.
- ARM (select=1, number=0, led_go=0):
  - delay_cnt decrements each tick.
  - At 0: go to RUN, led_go=1, elapsed=0.
  - react press before 0: FAULT with number=0 (false start).
  - start and mode presses: ignored.
- RUN (select=1, led_go=1, number=elapsed):
  - elapsed += MS_PER_TICK each tick.
  - react press: RESULT, number=elapsed at that edge, led_go=0.
  - elapsed reaches the current mode's limit with no press: FAULT, number=9999, led_go=0.
  - Press and limit on the same tick: press wins; RESULT with number=limit.
- RESULT (select=1): number held. start press → MENU with mode retained. Other buttons ignored.
- FAULT (select=2): number held. start press → MENU with mode retained.
- Width rules:
  - elapsed is 14-bit and saturates at 9999.
  - Limits are compile-time checked to be ≤9998 and multiples of MS_PER_TICK.
- Simultaneous presses in one tick:
  - start has priority over mode in MENU.
  - react has priority over start elsewhere.
- Reset mid-game: immediate return to MENU with mode=00. No pending press survives.
- Mode is frozen outside MENU.

Decomposition:
- Shared package holds:
  - state enum MENU/ARM/RUN/RESULT/FAULT
  - select encodings SEL_MENU=0, SEL_NUM=1, SEL_BLINK=2
  - mode encodings MODE_EASY/MODE_REG/MODE_HARD
  - FAULT_TIMEOUT_VAL=9999
- One sub-module: game_lfsr8 (clk, rst, seed, 8-bit out).

Test Plan:
- Reset, then mode held 3 ticks and released, repeated 3 times → mode 00→01→10→00, one step per press, select=0.
- Mode=01, start press; bench LFSR model predicts delay D; no react → led_go rises exactly D+1 edges later; after 500 ticks without react → FAULT, number=9999, select=2.
- Mode=00, start, wait for led_go, react press after 117 ticks → RESULT, number=234, select=1, led_go=0.
- Start, react press during ARM → FAULT, number=0, select=2, led_go never asserted; start press → MENU, mode unchanged.
- Mode=10, react press on the tick elapsed reaches 500 → RESULT, number=500 (not 9999).
- Assert rst during RUN → outputs number=0, select=0, mode=00, led_go=0 immediately (async); btn_start held across reset release yields no press until released and pressed again.

Source files
------------

// File: rtl/reaction_game_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// reaction_game_ctrl_pkg
// Shared types and encodings for the reaction game sequencer:
//   state_t            - top-level game states
//   SEL_*              - select codes understood by the seven-segment driver
//   MODE_*             - difficulty encodings (2'b11 is never produced)
//   FAULT_TIMEOUT_VAL  - number shown after a reaction timeout
//   next_mode()        - menu cycling order easy -> regular -> hard -> easy
// ----------------------------------------------------------------------------
package reaction_game_ctrl_pkg;

    typedef enum logic [2:0] {
        MENU,
        ARM,
        RUN,
        RESULT,
        FAULT
    } state_t;

    localparam logic [1:0] SEL_MENU  = 2'd0;
    localparam logic [1:0] SEL_NUM   = 2'd1;
    localparam logic [1:0] SEL_BLINK = 2'd2;

    localparam logic [1:0] MODE_EASY = 2'b00;
    localparam logic [1:0] MODE_REG  = 2'b01;
    localparam logic [1:0] MODE_HARD = 2'b10;

    localparam logic [13:0] FAULT_TIMEOUT_VAL = 14'd9999;

    function automatic logic [1:0] next_mode(input logic [1:0] m);
        case (m)
            MODE_EASY: return MODE_REG;
            MODE_REG:  return MODE_HARD;
            default:   return MODE_EASY;
        endcase
    endfunction

endpackage

// File: rtl/reaction_game_ctrl_lfsr.sv
// ----------------------------------------------------------------------------
// game_lfsr8
// 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1 (maximal length,
// 255 states). Free-running: advances on every clock edge out of reset.
//   clk  - tick clock
//   rst  - asynchronous, active-high; loads seed
//   seed - reset value, must be nonzero (all-zero is a lock-up state)
//   q    - current LFSR value
// ----------------------------------------------------------------------------
module game_lfsr8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seed,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= seed;
        end else begin
            // taps 8,6,5,4 -> bits 7,5,4,3; shift toward the MSB
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

endmodule

// File: rtl/reaction_game_ctrl.sv
// ----------------------------------------------------------------------------
// reaction_game_ctrl
// Top-level sequencer for the reaction game, one tick = one clk_500Hz cycle.
// Flow: mode menu -> random arm delay -> GO (measure reaction) -> result or
// fault screen -> back to the menu on a start press.
//   clk_500Hz  - tick clock (2 ms)
//   rst        - asynchronous, active-high reset
//   btn_start  - debounced start button level
//   btn_react  - debounced reaction button level
//   btn_mode   - debounced mode button level
//   number     - value for the display driver, 0..9999
//   select     - display mode: 0 menu, 1 steady number, 2 blinking number
//   mode       - difficulty: 00 easy, 01 regular, 10 hard
//   led_go     - lit while waiting for the reaction press
// All outputs are registered and change on the edge that samples the press.
// ----------------------------------------------------------------------------
module reaction_game_ctrl
    import reaction_game_ctrl_pkg::*;
#(
    parameter int         DELAY_MIN_TICKS = 250,
    parameter int         LIMIT_EASY_MS   = 2000,
    parameter int         LIMIT_REG_MS    = 1000,
    parameter int         LIMIT_HARD_MS   = 500,
    parameter int         MS_PER_TICK     = 2,
    parameter logic [7:0] LFSR_SEED       = 8'h01
) (
    input  logic        clk_500Hz,
    input  logic        rst,
    input  logic        btn_start,
    input  logic        btn_react,
    input  logic        btn_mode,
    output logic [13:0] number,
    output logic [1:0]  select,
    output logic [1:0]  mode,
    output logic        led_go
);

    localparam logic [9:0]  DELAY_MIN = 10'(DELAY_MIN_TICKS);
    localparam logic [13:0] STEP      = 14'(MS_PER_TICK);
    localparam logic [13:0] LIM_EASY  = 14'(LIMIT_EASY_MS);
    localparam logic [13:0] LIM_REG   = 14'(LIMIT_REG_MS);
    localparam logic [13:0] LIM_HARD  = 14'(LIMIT_HARD_MS);

    // A limit above 9998 could never be told apart from the timeout code, and
    // one that is not a multiple of the step would be skipped over.
    if (LIMIT_EASY_MS > 9998 || LIMIT_REG_MS > 9998 || LIMIT_HARD_MS > 9998 ||
        MS_PER_TICK < 1 ||
        (LIMIT_EASY_MS % MS_PER_TICK) != 0 ||
        (LIMIT_REG_MS  % MS_PER_TICK) != 0 ||
        (LIMIT_HARD_MS % MS_PER_TICK) != 0) begin : g_bad_limits
        $error("reaction_game_ctrl: limits must be <= 9998 and multiples of MS_PER_TICK");
    end
    if (LFSR_SEED == 8'h00) begin : g_bad_seed
        $error("reaction_game_ctrl: LFSR_SEED must be nonzero");
    end

    state_t      state;
    logic [9:0]  delay_cnt;
    logic [13:0] elapsed;
    logic [13:0] elapsed_step;
    logic [14:0] elapsed_sum;
    logic [13:0] limit;
    logic [7:0]  lfsr;
    logic [2:0]  btns;
    logic [2:0]  btn_prev;
    logic [2:0]  press;
    logic        primed;
    logic        start_p;
    logic        react_p;
    logic        mode_p;

    game_lfsr8 u_lfsr (
        .clk  (clk_500Hz),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    // Rising-edge detect. primed stays low for the first tick after reset so a
    // button already held while reset releases is absorbed into btn_prev
    // instead of firing; it has to be released and pressed again.
    assign btns    = {btn_start, btn_react, btn_mode};
    assign press   = btns & ~btn_prev & {3{primed}};
    assign start_p = press[2];
    assign react_p = press[1];
    assign mode_p  = press[0];

    // Elapsed time as it will be after this tick, saturating at 9999.
    assign elapsed_sum  = {1'b0, elapsed} + {1'b0, STEP};
    assign elapsed_step = (elapsed_sum > {1'b0, FAULT_TIMEOUT_VAL}) ?
                          FAULT_TIMEOUT_VAL : elapsed_sum[13:0];

    always_comb begin
        case (mode)
            MODE_REG:  limit = LIM_REG;
            MODE_HARD: limit = LIM_HARD;
            default:   limit = LIM_EASY;
        endcase
    end

    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            state     <= MENU;
            number    <= '0;
            select    <= SEL_MENU;
            mode      <= MODE_EASY;
            led_go    <= 1'b0;
            delay_cnt <= '0;
            elapsed   <= '0;
            btn_prev  <= '0;
            primed    <= 1'b0;
        end else begin
            btn_prev <= btns;
            primed   <= 1'b1;
            case (state)
                MENU: begin
                    if (start_p) begin
                        delay_cnt <= DELAY_MIN + {2'b00, lfsr};
                        number    <= '0;
                        select    <= SEL_NUM;
                        state     <= ARM;
                    end else if (mode_p) begin
                        mode <= next_mode(mode);
                    end
                end
                ARM: begin
                    // A react press while the LED is still dark is a false
                    // start, including on the tick the delay expires.
                    if (react_p) begin
                        number <= '0;
                        select <= SEL_BLINK;
                        state  <= FAULT;
                    end else if (delay_cnt == '0) begin
                        elapsed <= '0;
                        number  <= '0;
                        led_go  <= 1'b1;
                        state   <= RUN;
                    end else begin
                        delay_cnt <= delay_cnt - 10'd1;
                    end
                end
                RUN: begin
                    // The press is credited with this tick's time, so a press
                    // on the tick the limit is reached still scores the limit.
                    if (react_p) begin
                        number <= elapsed_step;
                        led_go <= 1'b0;
                        state  <= RESULT;
                    end else if (elapsed_step >= limit) begin
                        number <= FAULT_TIMEOUT_VAL;
                        select <= SEL_BLINK;
                        led_go <= 1'b0;
                        state  <= FAULT;
                    end else begin
                        elapsed <= elapsed_step;
                        number  <= elapsed_step;
                    end
                end
                RESULT, FAULT: begin
                    // react outranks start here, so a combined press is dropped
                    if (start_p && !react_p) begin
                        number <= '0;
                        select <= SEL_MENU;
                        state  <= MENU;
                    end
                end
                default: begin
                    number <= '0;
                    select <= SEL_MENU;
                    led_go <= 1'b0;
                    state  <= MENU;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// ----------------------------------------------------------------------------
// tb_reaction_game_ctrl
// Scoreboard bench for reaction_game_ctrl. The stimulus side works out, from
// the game rules, which visible screen change each press should cause and on
// which tick, and queues it. The monitor watches {select, mode, led_go} on the
// falling edge; every change pops one expectation and checks the full output
// set and the tick it appeared on.
// ----------------------------------------------------------------------------
module tb_reaction_game_ctrl;

    localparam logic [2:0] B_START = 3'b100;
    localparam logic [2:0] B_REACT = 3'b010;
    localparam logic [2:0] B_MODE  = 3'b001;

    logic        clk_500Hz = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  btns = 3'b000;
    logic [13:0] number;
    logic [1:0]  select;
    logic [1:0]  mode;
    logic        led_go;

    reaction_game_ctrl dut (
        .clk_500Hz (clk_500Hz),
        .rst       (rst),
        .btn_start (btns[2]),
        .btn_react (btns[1]),
        .btn_mode  (btns[0]),
        .number    (number),
        .select    (select),
        .mode      (mode),
        .led_go    (led_go)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    int tick = 0;
    always @(posedge clk_500Hz) tick++;

    typedef struct {
        int t;
        int num;
        int sel;
        int md;
        int led;
        bit anyt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   rst_tick = 0;
    int   model_mode = 0;

    // LFSR value seen by the edge that comes n ticks after the first
    // post-reset edge: new bit is the parity of taps 8,6,5,4.
    function automatic logic [7:0] lfsr_at(int n);
        logic [7:0] q = 8'h01;
        for (int i = 0; i < n; i++) q = {q[6:0], ^(q & 8'hB8)};
        return q;
    endfunction

    function automatic int limit_ms(int md);
        return (md == 0) ? 2000 : (md == 1) ? 1000 : 500;
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(int t, int num, int sel, int md, int led, bit anyt);
        exp_t e;
        e.t = t; e.num = num; e.sel = sel; e.md = md; e.led = led; e.anyt = anyt;
        exp_q.push_back(e);
    endtask

    // Raise the masked buttons so the edge numbered 'target' samples them,
    // keep them up for 'hold' ticks, then release. Called on a falling edge.
    task automatic press_at(logic [2:0] mask, int target, int hold);
        while (tick < target - 1) @(negedge clk_500Hz);
        btns = btns | mask;
        repeat (hold) @(negedge clk_500Hz);
        btns = btns & ~mask;
    endtask

    task automatic go_mode(int target);
        int e;
        while (model_mode != target) begin
            e = tick + 2;
            model_mode = (model_mode + 1) % 3;
            expect_out(e, 0, 0, model_mode, 0, 0);
            press_at(B_MODE, e, 1);
        end
    endtask

    // Start a round from the menu in mode md and return the start edge.
    // combo adds a mode press on the same edge, which must be ignored.
    task automatic start_round(int md, bit combo, output int s, output int d);
        go_mode(md);
        s = tick + 2;
        d = 250 + int'(lfsr_at(s - rst_tick - 1));
        expect_out(s, 0, 1, model_mode, 0, 0);
        press_at(combo ? (B_START | B_MODE) : B_START, s, 1);
        // start and mode presses while armed change nothing
        press_at(B_MODE, s + 2, 1);
        press_at(B_START, s + 4, 1);
    endtask

    // One full game. false_k > 0: react on the k-th tick after start.
    // Otherwise react_n > 0 presses react n ticks after GO; 0 means never.
    task automatic play(int md, int react_n, int false_k, bit combo);
        int s, d, g, lim, f, e;
        start_round(md, combo, s, d);
        if (false_k > 0) begin
            expect_out(s + false_k, 0, 2, model_mode, 0, 0);
            press_at(B_REACT, s + false_k, 1);
        end else begin
            g = s + d + 1;
            expect_out(g, 0, 1, model_mode, 1, 0);
            lim = limit_ms(model_mode);
            if (react_n > 0 && 2 * react_n <= lim) begin
                expect_out(g + react_n, 2 * react_n, 1, model_mode, 0, 0);
                press_at(B_REACT, g + react_n, 1);
            end else begin
                f = g + lim / 2;
                expect_out(f, 9999, 2, model_mode, 0, 0);
                if (react_n > 0) press_at(B_REACT, g + react_n, 1);
                while (tick < f + 1) @(negedge clk_500Hz);
            end
        end
        // start together with react is dropped; start alone returns to menu
        press_at(B_START | B_REACT, tick + 2, 1);
        e = tick + 2;
        expect_out(e, 0, 0, model_mode, 0, 0);
        press_at(B_START, e, 1);
    endtask

    task automatic reset_mid_run();
        int s, d, g;
        start_round(int'($urandom_range(1, 2)), 1'b0, s, d);
        g = s + d + 1;
        expect_out(g, 0, 1, model_mode, 1, 0);
        while (tick < g + 10) @(negedge clk_500Hz);
        expect_out(0, 0, 0, 0, 0, 1);
        btns = B_START;
        rst = 1'b1;
        #1;
        check("async_rst_number", int'(number), 0);
        check("async_rst_select", int'(select), 0);
        check("async_rst_mode", int'(mode), 0);
        check("async_rst_led", int'(led_go), 0);
        model_mode = 0;
        repeat (3) @(negedge clk_500Hz);
        rst = 1'b0;
        rst_tick = tick;
        // start held through reset release must not register
        repeat (5) @(negedge clk_500Hz);
        btns = 3'b000;
        play(0, 0, int'($urandom_range(6, 200)), 1'b0);
    endtask

    // Monitor: every visible screen change consumes one expectation.
    logic [4:0] prev = 5'b0;
    always @(negedge clk_500Hz) begin
        logic [4:0] cur;
        exp_t       e;
        bit         ok;
        cur = {select, mode, led_go};
        if (cur !== prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change: tick=%0d num=%0d sel=%0d mode=%0d led=%0d",
                         tick, number, select, mode, led_go);
            end else begin
                e = exp_q.pop_front();
                ok = (int'(number) == e.num) && (int'(select) == e.sel) &&
                     (int'(mode) == e.md) && (int'(led_go) == e.led) &&
                     (e.anyt || tick == e.t);
                if (!ok) begin
                    failures++;
                    $display("FAIL screen_change: got tick=%0d num=%0d sel=%0d mode=%0d led=%0d, want tick=%0d num=%0d sel=%0d mode=%0d led=%0d",
                             tick, number, select, mode, led_go, e.t, e.num, e.sel, e.md, e.led);
                end
            end
        end
        prev = cur;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: tick=%0d, want completion", tick);
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int md, kind, lim;
        #1;
        check("reset_number", int'(number), 0);
        check("reset_select", int'(select), 0);
        check("reset_mode", int'(mode), 0);
        check("reset_led", int'(led_go), 0);
        repeat (2) @(negedge clk_500Hz);
        rst = 1'b0;
        rst_tick = tick;
        repeat (2) @(negedge clk_500Hz);

        // mode held for 3 ticks steps exactly once per press
        for (int i = 0; i < 3; i++) begin
            int e;
            e = tick + 2;
            model_mode = (model_mode + 1) % 3;
            expect_out(e, 0, 0, model_mode, 0, 0);
            press_at(B_MODE, e, 3);
            repeat (2) @(negedge clk_500Hz);
        end

        play(1, 0, 0, 1'b0);      // regular, no reaction -> 9999 timeout
        play(0, 117, 0, 1'b0);    // easy, 117 ticks -> 234 ms
        play(model_mode, 0, 40, 1'b0); // false start, mode unchanged after
        play(2, 250, 0, 1'b1);    // hard, press on the limit tick -> 500

        for (int i = 0; i < 6; i++) begin
            md   = int'($urandom_range(0, 2));
            kind = int'($urandom_range(0, 2));
            lim  = limit_ms(md);
            case (kind)
                0:       play(md, 0, int'($urandom_range(6, 250)), 1'b0);
                1:       play(md, int'($urandom_range(1, lim / 2)), 0, 1'b0);
                default: play(md, lim / 2 + int'($urandom_range(1, 30)), 0, 1'b0);
            endcase
        end

        reset_mid_run();

        repeat (5) @(negedge clk_500Hz);
        check("expectations_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
